dvi_timing_adapter: RTL and testbench

DVI_TIMING_ADAPTER -- requirements
Module: dvi_timing_adapter

---
 rtl/dvi_timing_adapter.sv | 174 +++++++++++++++++
 tb/tb_dvi_timing_adapter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_timing_adapter.sv
// DVI timing adapter: buffers an upstream valid/ready pixel stream in a small
// FIFO and replays it against a fixed raster (active, porches, syncs).
// The raster does not start until the FIFO has been filled once, and after
// that it never stalls; an empty FIFO in an active cycle produces a black
// pixel and sets the sticky Underflow flag.
//
// Upstream handshake: a pixel transfers on a rising clock edge where
// VideoValid && VideoReady. VideoReady is a register (no combinational path
// from any input); Video must be held while VideoValid waits for VideoReady.
module dvi_timing_adapter #(
    parameter int HActive   = 800,
    parameter int HFront    = 40,
    parameter int HSyncW    = 128,
    parameter int HBack     = 88,
    parameter int VActive   = 600,
    parameter int VFront    = 1,
    parameter int VSyncW    = 4,
    parameter int VBack     = 23,
    parameter int FifoDepth = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] Video,
    input  logic        VideoValid,
    output logic        VideoReady,
    output logic [23:0] DVIData,
    output logic        DVIHSync,
    output logic        DVIVSync,
    output logic        DVIDataEnable,
    output logic        Underflow,
    output logic        DebugState
);

    localparam int HTotal = HActive + HFront + HSyncW + HBack;
    localparam int VTotal = VActive + VFront + VSyncW + VBack;
    localparam int HW     = $clog2(HTotal + 1);
    localparam int VW     = $clog2(VTotal + 1);
    localparam int PW     = $clog2(FifoDepth);
    localparam int CW     = PW + 1;

    localparam logic [HW-1:0] H_ACT    = HW'(HActive);
    localparam logic [HW-1:0] H_SYNC_S = HW'(HActive + HFront);
    localparam logic [HW-1:0] H_SYNC_E = HW'(HActive + HFront + HSyncW);
    localparam logic [HW-1:0] H_LAST   = HW'(HTotal - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(VActive);
    localparam logic [VW-1:0] V_SYNC_S = VW'(VActive + VFront);
    localparam logic [VW-1:0] V_SYNC_E = VW'(VActive + VFront + VSyncW);
    localparam logic [VW-1:0] V_LAST   = VW'(VTotal - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FifoDepth);

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [HW-1:0]  h_q, h_d;
    logic [VW-1:0]  v_q, v_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic           ready_q, ready_d;
    logic [23:0]    data_q, data_d;
    logic           de_q, de_d;
    logic           hs_q, hs_d;
    logic           vs_q, vs_d;
    logic           uf_q, uf_d;
    logic [23:0]    mem [FifoDepth];

    logic in_run, active, empty, push, pop, hs_win, vs_win;

    assign in_run = (state_q == S_RUN);
    assign active = in_run && (h_q < H_ACT) && (v_q < V_ACT);
    assign empty  = (count_q == '0);
    assign push   = VideoValid && ready_q;
    assign pop    = active && !empty;
    assign hs_win = in_run && (h_q >= H_SYNC_S) && (h_q < H_SYNC_E);
    assign vs_win = in_run && (v_q >= V_SYNC_S) && (v_q < V_SYNC_E);

    // FSM next state and raster counters; counters sit at 0 until RUN.
    always_comb begin
        state_d = state_q;
        h_d     = '0;
        v_d     = '0;
        case (state_q)
            S_FILL: begin
                if (count_q == DEPTH_C) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
                end else begin
                    h_d = h_q + HW'(1);
                    v_d = v_q;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // FIFO bookkeeping and the next values of the registered outputs.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        ready_d = (count_d < DEPTH_C);
        data_d  = pop ? mem[rd_ptr_q] : 24'h000000;
        de_d    = active;
        hs_d    = hs_win;
        vs_d    = vs_win;
        uf_d    = uf_q | (active && empty);
    end

    // State, counters, FIFO control and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_FILL;
            h_q      <= '0;
            v_q      <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
            data_q   <= '0;
            de_q     <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
            data_q   <= data_d;
            de_q     <= de_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            uf_q     <= uf_d;
        end
    end

    // Pixel storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= Video;
        end
    end

    assign VideoReady    = ready_q;
    assign DVIData       = data_q;
    assign DVIDataEnable = de_q;
    assign DVIHSync      = hs_q;
    assign DVIVSync      = vs_q;
    assign Underflow     = uf_q;
    assign DebugState    = (state_q == S_RUN);

endmodule

// File: tb/tb_dvi_timing_adapter.sv
// Bench for dvi_timing_adapter with a shrunken raster so full frames fit in
// a short run. A queue-based reference model predicts every output each
// cycle; a fill table and hand-written sequences cover the corner cases.
module tb_dvi_timing_adapter;

    localparam int HA = 6, HF = 2, HS = 3, HB = 2;
    localparam int VA = 3, VF = 1, VS = 2, VB = 1;
    localparam int DEPTH = 8;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int NT = 3 * FR;

    logic        clk;
    logic        reset;
    logic [23:0] Video;
    logic        VideoValid;
    logic        VideoReady;
    logic [23:0] DVIData;
    logic        DVIHSync;
    logic        DVIVSync;
    logic        DVIDataEnable;
    logic        Underflow;
    logic        DebugState;

    int checks = 0;
    int failures = 0;

    dvi_timing_adapter #(
        .HActive(HA), .HFront(HF), .HSyncW(HS), .HBack(HB),
        .VActive(VA), .VFront(VF), .VSyncW(VS), .VBack(VB),
        .FifoDepth(DEPTH)
    ) dut (
        .clock(clk),
        .reset(reset),
        .Video(Video),
        .VideoValid(VideoValid),
        .VideoReady(VideoReady),
        .DVIData(DVIData),
        .DVIHSync(DVIHSync),
        .DVIVSync(DVIVSync),
        .DVIDataEnable(DVIDataEnable),
        .Underflow(Underflow),
        .DebugState(DebugState)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Raster position is just the number of cycles spent in RUN, split into
    // line and column with division; the FIFO is a plain queue.
    logic [23:0] exp_q[$];
    bit          m_init = 0;
    bit          m_run;
    int          m_t;
    logic        m_ready, m_de, m_hs, m_vs, m_uf;
    logic [23:0] m_data;

    task automatic model_step();
        int  h, v;
        bit  push, go_run;
        if (reset) begin
            exp_q.delete();
            m_run = 0; m_t = 0; m_ready = 0; m_de = 0; m_hs = 0; m_vs = 0;
            m_uf = 0; m_data = '0; m_init = 1;
        end else if (m_init) begin
            push   = VideoValid && m_ready;
            go_run = !m_run && (exp_q.size() == DEPTH);
            m_de = 0; m_hs = 0; m_vs = 0; m_data = '0;
            if (m_run) begin
                h = m_t % HT;
                v = m_t / HT;
                m_de = (h < HA) && (v < VA);
                m_hs = (h >= HA + HF) && (h < HA + HF + HS);
                m_vs = (v >= VA + VF) && (v < VA + VF + VS);
                if (m_de) begin
                    if (exp_q.size() > 0) m_data = exp_q.pop_front();
                    else m_uf = 1;
                end
                m_t = (m_t + 1) % FR;
            end
            if (go_run) m_run = 1;
            if (push) exp_q.push_back(Video);
            m_ready = (exp_q.size() < DEPTH);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Scoreboard: every cycle, every output against the model.
    initial forever begin
        @(negedge clk);
        if (m_init) begin
            check("mon_ready", 24'(VideoReady), 24'(m_ready));
            check("mon_data", DVIData, m_data);
            check("mon_de", 24'(DVIDataEnable), 24'(m_de));
            check("mon_hsync", 24'(DVIHSync), 24'(m_hs));
            check("mon_vsync", 24'(DVIVSync), 24'(m_vs));
            check("mon_underflow", 24'(Underflow), 24'(m_uf));
        end
    end

    // ---------------- driver tasks ----------------
    int pat_i = 0;

    task automatic do_reset(input int n);
        reset = 1'b1;
        VideoValid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
        reset = 1'b0;
    endtask

    // Pattern stream: 64 x FF33FF, 64 x FF3333, repeating.
    task automatic tick(input logic v);
        VideoValid = v;
        Video = ((pat_i / 64) % 2 == 1) ? 24'hFF3333 : 24'hFF33FF;
        if (v && VideoReady) pat_i++;
        @(negedge clk);
    endtask

    task automatic rtick();
        VideoValid = ($urandom_range(0, 3) != 0);
        Video = 24'($urandom);
        @(negedge clk);
    endtask

    // ---------------- fill table ----------------
    typedef struct {
        logic        valid;
        logic [23:0] pix;
        logic        exp_ready;
        logic        exp_de;
        logic [23:0] exp_data;
        logic        exp_run;
    } vec_t;
    vec_t tbl [12];

    bit tr_de [NT];
    bit tr_hs [NT];
    bit tr_vs [NT];
    int r, n, m, q, s, f, cnt, guard;
    bit seen_black;

    initial begin
        reset = 1'b1;
        VideoValid = 1'b0;
        Video = '0;

        // Row i is the edge i+1 after reset release; the FIFO takes DEPTH
        // pixels, RUN starts one cycle after it is full, and the first
        // active pixel appears one cycle after that.
        for (int i = 0; i < 12; i++) begin
            tbl[i].valid     = 1'b1;
            tbl[i].pix       = 24'hFF33FF;
            tbl[i].exp_ready = (i < DEPTH) || (i >= DEPTH + 2);
            tbl[i].exp_de    = (i >= DEPTH + 2);
            tbl[i].exp_data  = (i >= DEPTH + 2) ? 24'hFF33FF : 24'h000000;
            tbl[i].exp_run   = (i >= DEPTH + 1);
        end

        do_reset(2);
        check("rst_ready", 24'(VideoReady), 24'd0);
        check("rst_data", DVIData, 24'd0);
        check("rst_de", 24'(DVIDataEnable), 24'd0);
        check("rst_hsync", 24'(DVIHSync), 24'd0);
        check("rst_vsync", 24'(DVIVSync), 24'd0);
        check("rst_underflow", 24'(Underflow), 24'd0);
        check("rst_state", 24'(DebugState), 24'd0);

        for (int i = 0; i < 12; i++) begin
            VideoValid = tbl[i].valid;
            Video = tbl[i].pix;
            @(negedge clk);
            check($sformatf("fill_ready[%0d]", i), 24'(VideoReady), 24'(tbl[i].exp_ready));
            check($sformatf("fill_de[%0d]", i), 24'(DVIDataEnable), 24'(tbl[i].exp_de));
            check($sformatf("fill_data[%0d]", i), DVIData, tbl[i].exp_data);
            check($sformatf("fill_run[%0d]", i), 24'(DebugState), 24'(tbl[i].exp_run));
        end

        // Line and frame timing under a continuous pattern stream.
        pat_i = 0;
        for (int i = 0; i < NT; i++) begin
            tick(1'b1);
            tr_de[i] = DVIDataEnable;
            tr_hs[i] = DVIHSync;
            tr_vs[i] = DVIVSync;
        end
        check("stream_underflow", 24'(Underflow), 24'd0);

        r = -1;
        for (int i = 1; i < NT; i++) if (r < 0 && tr_de[i] && !tr_de[i-1]) r = i;
        check("de_rise_found", 24'(r >= 0), 24'd1);
        if (r >= 0) begin
            n = 0;
            while (r + n < NT && tr_de[r+n]) n++;
            check("de_high_len", 24'(n), 24'(HA));
            m = 0;
            while (r + n + m < NT && !tr_de[r+n+m]) m++;
            check("de_low_len", 24'(m), 24'(HT - HA));
            q = -1;
            for (int i = r; i < NT; i++) if (q < 0 && tr_hs[i] && !tr_hs[i-1]) q = i;
            check("hs_offset", 24'(q - r), 24'(HA + HF));
            n = 0;
            while (q >= 0 && q + n < NT && tr_hs[q+n]) n++;
            check("hs_len", 24'(n), 24'(HS));
            check("line_period", 24'({tr_de[r+HT], tr_de[r+HT-1]}), 24'b10);
        end

        s = -1;
        for (int i = 1; i < NT; i++) if (s < 0 && tr_vs[i] && !tr_vs[i-1]) s = i;
        check("vs_rise_found", 24'(s >= 0 && s + FR < NT), 24'd1);
        if (s >= 0 && s + FR < NT) begin
            n = 0;
            while (s + n < NT && tr_vs[s+n]) n++;
            check("vs_len", 24'(n), 24'(VS * HT));
            check("frame_period", 24'({tr_vs[s+FR], tr_vs[s+FR-1]}), 24'b10);
            f = s + (VT - VA - VF) * HT;
            check("vs_line_pos", 24'({tr_de[f], tr_de[f-1]}), 24'b10);
            cnt = 0;
            for (int i = 0; i < FR; i++) if (f + i < NT && tr_de[f+i]) cnt++;
            check("de_per_frame", 24'(cnt), 24'(HA * VA));
        end

        // Mid-frame reset at column 3 of line 1.
        guard = 0;
        while (!(m_run && (m_t % HT) == 3 && (m_t / HT) == 1) && guard < 4 * FR) begin
            tick(1'b1);
            guard++;
        end
        check("midreset_reached", 24'(guard < 4 * FR), 24'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mr_ready", 24'(VideoReady), 24'd0);
        check("mr_data", DVIData, 24'd0);
        check("mr_de", 24'(DVIDataEnable), 24'd0);
        check("mr_hsync", 24'(DVIHSync), 24'd0);
        check("mr_vsync", 24'(DVIVSync), 24'd0);
        check("mr_state", 24'(DebugState), 24'd0);
        reset = 1'b0;
        tick(1'b1);
        check("mr_ready_after", 24'(VideoReady), 24'd1);
        check("mr_de_after", 24'(DVIDataEnable), 24'd0);

        // Underflow: refill, then starve the FIFO, then resume.
        for (int i = 0; i < 30; i++) tick(1'b1);
        check("uf_before", 24'(Underflow), 24'd0);
        seen_black = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            tick(1'b0);
            if (DVIDataEnable && DVIData == 24'h000000) seen_black = 1;
        end
        check("uf_black_pixel", 24'(seen_black), 24'd1);
        check("uf_set", 24'(Underflow), 24'd1);
        for (int i = 0; i < 50; i++) tick(1'b1);
        check("uf_sticky", 24'(Underflow), 24'd1);
        check("uf_still_run", 24'(DebugState), 24'd1);

        // Random traffic from a fresh reset, checked by the model.
        do_reset(1);
        for (int i = 0; i < 4 * FR; i++) rtick();

        VideoValid = 1'b0;
        @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
